// File: rtl/out_uart_pkg.sv
// out_uart_pkg: shared serializer state encoding and frame constants
package out_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/out_byte_fifo.sv
// out_byte_fifo: byte queue with count/full and sticky overflow when a write hits a full queue
module out_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign full = count == CW'(DEPTH);
  assign wr = wr_en && !full;
  assign rd = rd_en && count != '0;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + CW'(wr) - CW'(rd);
      overflow <= overflow | (wr_en && full);
    end
  end
endmodule

// File: rtl/out_port_uart.sv
// out_port_uart: queues OUT_Port bytes and serializes them 8N1 on tx (even parity with OUT_UART_PARITY_EN)
module out_port_uart
  import out_uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             out_data,
  input  logic                   out_valid,
  output logic                   tx,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_full,
  output logic                   overflow
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  uart_state_t state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0] idx, idx_d;
  logic [7:0] sh, sh_d, head;
  logic tx_d, busy_d, pop, bit_end, queued, data_step;
  out_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(out_valid),
    .wr_data(out_data),
    .rd_en(pop),
    .rd_data(head),
    .count(fifo_count),
    .full(fifo_full),
    .overflow(overflow)
  );
  assign queued = fifo_count != '0;
  assign bit_end = baud == LAST;
  assign data_step = state == DATA && bit_end;
  assign pop = queued && (state == IDLE || (state == STOP && bit_end));
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      baud <= '0;
      idx <= '0;
      sh <= '0;
      tx <= UART_IDLE_LEVEL;
      tx_busy <= 1'b0;
    end else begin
      state <= state_d;
      baud <= baud_d;
      idx <= idx_d;
      sh <= sh_d;
      tx <= tx_d;
      tx_busy <= busy_d;
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:   state_d = pop ? START : IDLE;
      START:  state_d = bit_end ? DATA : START;
`ifdef OUT_UART_PARITY_EN
      DATA:   state_d = (bit_end && idx == 3'(UART_DATA_BITS - 1)) ? PARITY : DATA;
      PARITY: state_d = bit_end ? STOP : PARITY;
`else
      DATA:   state_d = (bit_end && idx == 3'(UART_DATA_BITS - 1)) ? STOP : DATA;
`endif
      STOP:   state_d = bit_end ? (queued ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
  end
  // shift register rotates, so it holds the original byte again when DATA ends (used for parity)
  always_comb begin
    baud_d = (bit_end || state_d != state || state == IDLE) ? '0 : baud + 1'b1;
    idx_d = data_step ? idx + 1'b1 : idx;
    sh_d = pop ? head : data_step ? {sh[0], sh[7:1]} : sh;
    tx_d = state_d == START ? 1'b0 :
           state_d == DATA ? sh_d[0] :
`ifdef OUT_UART_PARITY_EN
           state_d == PARITY ? ^sh_d :
`endif
           UART_IDLE_LEVEL;
    busy_d = state_d != IDLE;
  end
endmodule
